// File: rtl/lcd_write_arbiter_if.sv
// rtl/lcd_write_arbiter_if.sv - requester, LCD write and status signals of the LCD write arbiter
interface lcd_write_arbiter_if;
    logic        cpu_wr_en;
    logic [31:0] cpu_wr_data;
    logic        kbd_wr_en;
    logic [7:0]  kbd_wr_data;
    logic        clr_ovf;
    logic        lcd_wr_en;
    logic [7:0]  lcd_wr_data;
    logic        lcd_src;
    logic        cpu_full;
    logic        kbd_full;
    logic        cpu_ovf;
    logic        kbd_ovf;
    logic        busy;

    modport master (
        output cpu_wr_en, cpu_wr_data, kbd_wr_en, kbd_wr_data, clr_ovf,
        input  lcd_wr_en, lcd_wr_data, lcd_src, cpu_full, kbd_full, cpu_ovf, kbd_ovf, busy
    );

    modport slave (
        input  cpu_wr_en, cpu_wr_data, kbd_wr_en, kbd_wr_data, clr_ovf,
        output lcd_wr_en, lcd_wr_data, lcd_src, cpu_full, kbd_full, cpu_ovf, kbd_ovf, busy
    );
endinterface

// File: rtl/lcd_write_arbiter.sv
// rtl/lcd_write_arbiter.sv - round-robin arbiter sharing the LCD character-write port between cpu and keyboard FIFOs
module lcd_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int GAP   = 16
) (
    input  logic               clock,
    input  logic               resetn,
    lcd_write_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   gap_cnt, gap_nxt;
    logic            issue, win, last;

    logic [7:0]      cpu_mem [DEPTH];
    logic [7:0]      kbd_mem [DEPTH];
    logic [PW-1:0]   cpu_rp, cpu_wp, kbd_rp, kbd_wp;
    logic [CW-1:0]   cpu_cnt, kbd_cnt;
    logic            cpu_is_full, kbd_is_full, cpu_push, kbd_push, cpu_pop, kbd_pop;
    logic            cpu_elig, kbd_elig;
    logic [7:0]      lcd_data_q;
    logic            lcd_en_q, lcd_src_q, cpu_ovf_q, kbd_ovf_q;
    logic            unused_cpu_hi;

    assign unused_cpu_hi = &{1'b0, bus.cpu_wr_data[31:8]};

    // Fullness is judged on the pre-edge count, so a same-cycle pop never rescues a push.
    assign cpu_is_full = (cpu_cnt == CW'(DEPTH));
    assign kbd_is_full = (kbd_cnt == CW'(DEPTH));
    assign cpu_push    = bus.cpu_wr_en && !cpu_is_full;
    assign kbd_push    = bus.kbd_wr_en && !kbd_is_full;
    assign cpu_elig    = (cpu_cnt != '0);
    assign kbd_elig    = (kbd_cnt != '0);

    // win: 0 = cpu, 1 = kbd; a tie goes to whichever side did not issue last.
    assign win     = (cpu_elig && kbd_elig) ? ~last : kbd_elig;
    assign cpu_pop = issue && !win;
    assign kbd_pop = issue && win;

    always_ff @(posedge clock) begin
        if (cpu_push) cpu_mem[cpu_wp] <= bus.cpu_wr_data[7:0];
        if (kbd_push) kbd_mem[kbd_wp] <= bus.kbd_wr_data;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cpu_rp  <= '0;
            cpu_wp  <= '0;
            cpu_cnt <= '0;
            kbd_rp  <= '0;
            kbd_wp  <= '0;
            kbd_cnt <= '0;
        end else begin
            if (cpu_push) cpu_wp <= cpu_wp + PW'(1);
            if (cpu_pop)  cpu_rp <= cpu_rp + PW'(1);
            if (kbd_push) kbd_wp <= kbd_wp + PW'(1);
            if (kbd_pop)  kbd_rp <= kbd_rp + PW'(1);
            cpu_cnt <= cpu_cnt + CW'(cpu_push) - CW'(cpu_pop);
            kbd_cnt <= kbd_cnt + CW'(kbd_push) - CW'(kbd_pop);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        issue     = 1'b0;
        case (state)
            S_IDLE: begin
                if (cpu_elig || kbd_elig) begin
                    issue     = 1'b1;
                    gap_nxt   = GW'(GAP - 1);
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (gap_cnt != '0) begin
                    gap_nxt = gap_cnt - GW'(1);
                end else if (cpu_elig || kbd_elig) begin
                    issue   = 1'b1;
                    gap_nxt = GW'(GAP - 1);
                end else begin
                    state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lcd_en_q   <= 1'b0;
            lcd_data_q <= '0;
            lcd_src_q  <= 1'b0;
            last       <= 1'b1;
            cpu_ovf_q  <= 1'b0;
            kbd_ovf_q  <= 1'b0;
        end else begin
            lcd_en_q <= issue;
            if (issue) begin
                lcd_data_q <= win ? kbd_mem[kbd_rp] : cpu_mem[cpu_rp];
                lcd_src_q  <= win;
                last       <= win;
            end
            // A dropped push outranks a coincident clear.
            if (bus.cpu_wr_en && cpu_is_full) cpu_ovf_q <= 1'b1;
            else if (bus.clr_ovf)             cpu_ovf_q <= 1'b0;
            if (bus.kbd_wr_en && kbd_is_full) kbd_ovf_q <= 1'b1;
            else if (bus.clr_ovf)             kbd_ovf_q <= 1'b0;
        end
    end

    assign bus.lcd_wr_en   = lcd_en_q;
    assign bus.lcd_wr_data = lcd_data_q;
    assign bus.lcd_src     = lcd_src_q;
    assign bus.cpu_full    = cpu_is_full;
    assign bus.kbd_full    = kbd_is_full;
    assign bus.cpu_ovf     = cpu_ovf_q;
    assign bus.kbd_ovf     = kbd_ovf_q;
    assign bus.busy        = cpu_elig || kbd_elig || (state == S_WAIT);
endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb/tb_lcd_write_arbiter.sv - directed self-checking bench for lcd_write_arbiter
module tb_lcd_write_arbiter;
    logic clock  = 1'b0;
    logic resetn = 1'b0;
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    lcd_write_arbiter_if a ();
    lcd_write_arbiter_if b ();

    lcd_write_arbiter #(.DEPTH(4), .GAP(16)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (a.slave)
    );

    lcd_write_arbiter #(.DEPTH(4), .GAP(1)) dut_g1 (
        .clock  (clock),
        .resetn (resetn),
        .bus    (b.slave)
    );

    logic [7:0] qa_d[$];
    logic       qa_s[$];
    int         qa_c[$];
    logic [7:0] qb_d[$];
    int         qb_c[$];

    always @(negedge clock) begin
        if (a.lcd_wr_en === 1'b1) begin
            qa_d.push_back(a.lcd_wr_data);
            qa_s.push_back(a.lcd_src);
            qa_c.push_back(cyc);
        end
        if (b.lcd_wr_en === 1'b1) begin
            qb_d.push_back(b.lcd_wr_data);
            qb_c.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic clear_q();
        qa_d.delete(); qa_s.delete(); qa_c.delete();
        qb_d.delete(); qb_c.delete();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick(2);
        resetn = 1'b1;
        tick(1);
        clear_q();
    endtask

    initial begin
        logic [7:0] exp6 [6];
        exp6 = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2};

        a.cpu_wr_en = 0; a.cpu_wr_data = 0; a.kbd_wr_en = 0; a.kbd_wr_data = 0; a.clr_ovf = 0;
        b.cpu_wr_en = 0; b.cpu_wr_data = 0; b.kbd_wr_en = 0; b.kbd_wr_data = 0; b.clr_ovf = 0;

        // reset state
        tick(2);
        check("rst_en",   a.lcd_wr_en, 0);
        check("rst_data", a.lcd_wr_data, 0);
        check("rst_src",  a.lcd_src, 0);
        check("rst_full", {a.cpu_full, a.kbd_full}, 0);
        check("rst_ovf",  {a.cpu_ovf, a.kbd_ovf}, 0);
        check("rst_busy", a.busy, 0);
        check("rst_g1",   {b.lcd_wr_en, b.busy}, 0);
        resetn = 1'b1;
        tick(1);

        // single cpu write
        a.cpu_wr_en = 1; a.cpu_wr_data = 32'hABCD_1241;
        tick(1);
        a.cpu_wr_en = 0;
        check("t1_en_edge1", a.lcd_wr_en, 0);
        tick(1);
        check("t1_en_edge2", a.lcd_wr_en, 1);
        check("t1_data", a.lcd_wr_data, 8'h41);
        check("t1_src",  a.lcd_src, 0);
        tick(1);
        check("t1_en_single", a.lcd_wr_en, 0);
        tick(14);
        check("t1_busy_wait", a.busy, 1);
        tick(1);
        check("t1_busy_done", a.busy, 0);
        check("t1_data_hold", a.lcd_wr_data, 8'h41);

        // tie after reset, then alternating load
        do_reset();
        a.cpu_wr_en = 1; a.cpu_wr_data = 32'h11;
        a.kbd_wr_en = 1; a.kbd_wr_data = 8'h22;
        tick(1);
        a.cpu_wr_en = 0; a.kbd_wr_en = 0;
        tick(40);
        check("t2_cnt",  qa_d.size(), 2);
        check("t2_d0",   qa_d[0], 8'h11);
        check("t2_s0",   qa_s[0], 0);
        check("t2_d1",   qa_d[1], 8'h22);
        check("t2_s1",   qa_s[1], 1);
        check("t2_gap",  qa_c[1] - qa_c[0], 16);
        clear_q();
        for (int i = 0; i < 3; i++) begin
            a.cpu_wr_en = 1; a.cpu_wr_data = 32'hA0 + i;
            a.kbd_wr_en = 1; a.kbd_wr_data = 8'hB0 + 8'(i);
            tick(1);
        end
        a.cpu_wr_en = 0; a.kbd_wr_en = 0;
        tick(6 * 16 + 20);
        check("t2_cnt6", qa_d.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t2_d%0d", i), qa_d[i], exp6[i]);
            check($sformatf("t2_s%0d", i), qa_s[i], i % 2);
            if (i > 0) check($sformatf("t2_gap%0d", i), qa_c[i] - qa_c[i-1], 16);
        end

        // GAP = 1 back-to-back
        do_reset();
        for (int i = 0; i < 4; i++) begin
            b.cpu_wr_en = 1; b.cpu_wr_data = 32'(i + 1);
            tick(1);
        end
        b.cpu_wr_en = 0;
        tick(10);
        check("t3_cnt", qb_d.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_d%0d", i), qb_d[i], i + 1);
            if (i > 0) check($sformatf("t3_gap%0d", i), qb_c[i] - qb_c[i-1], 1);
        end
        check("t3_busy", b.busy, 0);

        // overflow: hold the arbiter in WAIT with a cpu byte, then flood kbd
        do_reset();
        a.cpu_wr_en = 1; a.cpu_wr_data = 32'h99;
        tick(1);
        a.cpu_wr_en = 0;
        tick(1);
        for (int i = 0; i < 6; i++) begin
            a.kbd_wr_en = 1; a.kbd_wr_data = 8'h30 + 8'(i);
            tick(1);
        end
        a.kbd_wr_en = 0;
        check("t4_full",    a.kbd_full, 1);
        check("t4_ovf",     a.kbd_ovf, 1);
        check("t4_cpu_ovf", a.cpu_ovf, 0);
        tick(100);
        check("t4_cnt", qa_d.size(), 5);
        check("t4_d0",  qa_d[0], 8'h99);
        for (int i = 1; i < 5; i++)
            check($sformatf("t4_d%0d", i), qa_d[i], 8'h30 + i - 1);
        check("t4_full_drained", a.kbd_full, 0);
        check("t4_ovf_sticky",   a.kbd_ovf, 1);
        a.clr_ovf = 1;
        tick(1);
        a.clr_ovf = 0;
        check("t4_ovf_clr", a.kbd_ovf, 0);

        // clr_ovf coincident with a dropped push
        do_reset();
        a.cpu_wr_en = 1; a.cpu_wr_data = 32'h98;
        tick(1);
        a.cpu_wr_en = 0;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            a.kbd_wr_en = 1; a.kbd_wr_data = 8'h40 + 8'(i);
            tick(1);
        end
        check("t5_full",    a.kbd_full, 1);
        check("t5_ovf_pre", a.kbd_ovf, 0);
        a.kbd_wr_data = 8'h44; a.clr_ovf = 1;
        tick(1);
        a.kbd_wr_en = 0; a.clr_ovf = 0;
        check("t5_ovf_set_wins", a.kbd_ovf, 1);
        tick(100);

        // asynchronous reset mid-WAIT with bytes queued
        do_reset();
        a.kbd_wr_en = 1; a.kbd_wr_data = 8'h61;
        tick(1);
        a.kbd_wr_en = 0;
        for (int i = 0; i < 3; i++) begin
            a.cpu_wr_en = 1; a.cpu_wr_data = 32'h71 + i;
            tick(1);
        end
        a.cpu_wr_en = 0;
        tick(2);
        check("t6_pre_src",  a.lcd_src, 1);
        check("t6_pre_data", a.lcd_wr_data, 8'h61);
        check("t6_pre_busy", a.busy, 1);
        resetn = 1'b0;
        #1;
        check("t6_rst_en",   a.lcd_wr_en, 0);
        check("t6_rst_data", a.lcd_wr_data, 0);
        check("t6_rst_src",  a.lcd_src, 0);
        check("t6_rst_busy", a.busy, 0);
        check("t6_rst_full", {a.cpu_full, a.kbd_full}, 0);
        tick(3);
        resetn = 1'b1;
        clear_q();
        tick(40);
        check("t6_no_pulse", qa_d.size(), 0);
        check("t6_busy",     a.busy, 0);
        a.cpu_wr_en = 1; a.cpu_wr_data = 32'h5A;
        tick(1);
        a.cpu_wr_en = 0;
        check("t6_lat_edge1", a.lcd_wr_en, 0);
        tick(1);
        check("t6_lat_edge2", a.lcd_wr_en, 1);
        check("t6_lat_data",  a.lcd_wr_data, 8'h5A);
        check("t6_lat_src",   a.lcd_src, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lcd_write_arbiter.md
# lcd_write_arbiter

Shares the single character-write port of the `lcd` controller between two requesters: the processor's LCD write interface and the PS/2 keyboard's received-byte stream. Each requester has its own small FIFO. A round-robin grant FSM drains the FIFOs one byte at a time and spaces the writes by a programmable gap so the slow LCD controller is never overrun. It sits in `skeleton` between `processor`/`PS2_Interface` and `lcd`, and replaces the direct `ps2_out` hookup.

## Interface
- `DEPTH`, default 4: entries per requester FIFO. Must be a power of two and at least 2.
- `GAP`, default 16: minimum number of cycles between successive `lcd_wr_en` pulses. Must be at least 1.

- `clock`  in  1  system clock; all logic is on the rising edge.
- `resetn`  in  1  one clock; reset is asynchronous and active-low.
- `cpu_wr_en`  in  1  processor write strobe; one push per high cycle.
- `cpu_wr_data`  in  32  processor write data; only bits [7:0] are used.
- `kbd_wr_en`  in  1  keyboard byte-received strobe; one push per high cycle.
- `kbd_wr_data`  in  8  keyboard byte.
- `clr_ovf`  in  1  clears both overflow flags.
- `lcd_wr_en`  out  1  single-cycle write pulse to `lcd`.
- `lcd_wr_data`  out  8  byte presented with `lcd_wr_en`; holds its value between pulses.
- `lcd_src`  out  1  source of the last issued byte: 0 = cpu, 1 = kbd.
- `cpu_full`, `kbd_full`  out  1 each  FIFO count == DEPTH (registered).
- `cpu_ovf`, `kbd_ovf`  out  1 each  sticky flag; a push was dropped because the FIFO was full.
- `busy`  out  1  high when either FIFO is non-empty or the FSM is in WAIT.

## Operation
- **FIFOs:** one per requester, each with a read pointer, a write pointer and a count. Pointers wrap modulo DEPTH.
  - A push happens when `wr_en` is high and the registered count < DEPTH.
  - A push while full is dropped and sets `*_ovf`. This holds even if the same cycle pops that FIFO: fullness is judged on the pre-edge count.
  - Push and pop on the same edge: count is unchanged and both pointers advance.
- **Eligibility:** a FIFO is eligible when its registered count > 0. A byte pushed on edge t is eligible for grant at edge t+1 at the earliest.
- **Round-robin:** `last` register, reset value 1.
  - If only one FIFO is eligible, it wins.
  - If both are eligible, the FIFO that is not `last` wins.
  - `last` is updated to the winner on every issue.
- **Issue action (on one edge):**
  - pop the winner;
  - `lcd_wr_data` <= head byte;
  - `lcd_wr_en` <= 1 for exactly one cycle;
  - `lcd_src` <= winner;
  - `gap_cnt` <= GAP-1;
  - state <= WAIT.
- **FSM states:**
  - IDLE: if any FIFO is eligible, perform the issue action; otherwise stay in IDLE.
  - WAIT: if `gap_cnt` != 0, decrement it. If `gap_cnt` == 0 and a FIFO is eligible, perform the issue action and stay in WAIT. If `gap_cnt` == 0 and no FIFO is eligible, go to IDLE.
- **Overflow flags:** set on a dropped push; cleared by `clr_ovf`. If a set and a clear occur in the same cycle, set wins.
- **Reset (asynchronous, including mid-operation):** all outputs are 0, both FIFOs are empty, `gap_cnt` = 0, state = IDLE, `last` = 1. Bytes queued or in flight are discarded. No partial pulse is produced after reset releases.

## Timing
- **Latency:** a push on edge t into an empty, idle arbiter gives `lcd_wr_en` high in the cycle after edge t+1, i.e. 2 edges.
- **Spacing:** under continuous load, `lcd_wr_en` pulses are exactly GAP cycles apart (rising edge to rising edge). With GAP = 1 they fire on consecutive cycles.
- **Status timing:** `cpu_full`, `kbd_full` and `busy` are registered and reflect state after the most recent edge.
- **No back-pressure:** requesters must watch `*_full`; the arbiter never stalls them.
- **Throughput:** at most 1 byte per GAP cycles in total. With both FIFOs continuously non-empty the bytes alternate strictly cpu, kbd, cpu, …

## Test plan
- Single CPU write, `cpu_wr_data` = 0xABCD_1241, GAP = 16: one `lcd_wr_en` pulse 2 edges after the push, `lcd_wr_data` = 0x41, `lcd_src` = 0. `busy` falls to 0 once WAIT expires with both FIFOs empty.
- Tie after reset: push cpu 0x11 and kbd 0x22 on the same edge. The cpu byte issues first, then kbd 16 cycles later. Next push 3 cpu + 3 kbd bytes: order is cpu, kbd, cpu, kbd, cpu, kbd with pulses exactly 16 cycles apart.
- GAP = 1, 4 cpu bytes 0x01..0x04 preloaded: 4 pulses on consecutive cycles with data 0x01..0x04 in order.
- Overflow, DEPTH = 4: 6 back-to-back kbd pushes 0x30..0x35 before any issue. `kbd_full` = 1 and `kbd_ovf` = 1. The LCD receives 0x30..0x33 only; 0x34 and 0x35 are dropped. Pulsing `clr_ovf` gives `kbd_ovf` = 0.
- `clr_ovf` coincident with a dropped push: `kbd_ovf` stays 1.
- Reset mid-WAIT with 3 bytes queued: all outputs are 0 immediately. After release there are no `lcd_wr_en` pulses and `busy` = 0. The next push issues with the normal 2-edge latency.
